// File: rtl/musa_pkg.sv
// Shared fetch-stage definitions: FSM encoding, next-PC selects and reset defaults.
package musa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_JUMP   = 2'd2,
    PC_BRANCH = 2'd3
  } pc_sel_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  // Redirect targets are word addresses; stray low bits from ID are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC select: hold, sequential +4, jump or branch target.
module pc_reg
  import musa_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  pc_sel_t     sel,
  input  logic [31:0] jump_target,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] pc_inc
);

  // 32-bit add wraps naturally from FFFF_FFFC to 0000_0000.
  assign pc_inc = pc + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else begin
      unique case (sel)
        PC_HOLD:   pc <= pc;
        PC_INC:    pc <= pc_inc;
        PC_JUMP:   pc <= word_align(jump_target);
        PC_BRANCH: pc <= word_align(branch_target);
      endcase
    end
  end

endmodule

// File: rtl/stage_one_fetch.sv
// Instruction fetch stage: request FSM, PC select and the IF/ID pipeline register.
module stage_one_fetch
  import musa_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        if_valid,
  output logic [31:0] fetch_count
);

  fetch_state_t state;
  pc_sel_t      pc_sel;
  logic [31:0]  pc;
  logic [31:0]  pc_inc;
  logic         redirect;
  logic         deliver;

  // Redirects only matter while the pipeline advances; a stalled ID re-presents them.
  assign redirect = pc_write && (jump || branch_taken) && (state != STALL);
  assign deliver  = (state == FETCH) && pc_write && imem_ready && !redirect;

  always_comb begin
    pc_sel = PC_HOLD;
    if (redirect) begin
      pc_sel = jump ? PC_JUMP : PC_BRANCH;
    end else if (deliver) begin
      pc_sel = PC_INC;
    end
  end

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .sel          (pc_sel),
    .jump_target  (jump_target),
    .branch_target(branch_target),
    .pc           (pc),
    .pc_inc       (pc_inc)
  );

  assign imem_addr = pc;

  // FSM and IF/ID register; imem_req is registered alongside the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      instruction <= NOP_WORD;
      pc_plus4    <= 32'd0;
      if_valid    <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          state       <= FETCH;
          imem_req    <= 1'b1;
          instruction <= NOP_WORD;
          if_valid    <= 1'b0;
        end
        FETCH: begin
          if (!pc_write) begin
            state    <= STALL;
            imem_req <= 1'b0;
          end else begin
            imem_req <= 1'b1;
            if (deliver) begin
              instruction <= imem_rdata;
              pc_plus4    <= pc_inc;
              if_valid    <= 1'b1;
              fetch_count <= fetch_count + 32'd1;
            end else begin
              // Redirect squash or memory not ready: insert a bubble.
              instruction <= NOP_WORD;
              if_valid    <= 1'b0;
            end
          end
        end
        STALL: begin
          if (pc_write) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_one_fetch.sv
// Directed bench for stage_one_fetch: sequential fetch, stall, redirect, bubbles, wrap, reset.
module tb_stage_one_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_write = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic        imem_ready = 1'b1;

  logic        imem_req, if_valid;
  logic [31:0] imem_addr, imem_rdata, instruction, pc_plus4, fetch_count;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc4, w_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: each word reads back as its own address.
  assign imem_rdata = imem_addr;
  assign w_rdata    = w_addr;

  stage_one_fetch #(.RESET_PC(32'h0000_0000), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc_plus4(pc_plus4),
    .if_valid(if_valid), .fetch_count(fetch_count)
  );

  stage_one_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .pc_write(pc_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(imem_ready), .imem_rdata(w_rdata),
    .instruction(w_instr), .pc_plus4(w_pc4),
    .if_valid(w_valid), .fetch_count(w_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pc_write = 1'b1; jump = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    checks++; if (instruction !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", instruction, NOP); end
    checks++; if (pc_plus4 !== 32'd0) begin errors++; $display("FAIL reset_pc4: got %h want 0", pc_plus4); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", if_valid); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_sequential();
    do_reset();
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %0b want 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req: req %0b addr %h want 1 0", imem_req, imem_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instruction !== 32'(i * 4) || if_valid !== 1'b1 || imem_addr !== 32'(i * 4 + 4) || pc_plus4 !== 32'(i * 4 + 4))
        begin errors++; $display("FAIL seq_%0d: instr %h valid %0b addr %h pc4 %h want %h 1 %h %h", i, instruction, if_valid, imem_addr, pc_plus4, i * 4, i * 4 + 4, i * 4 + 4); end
    end
    checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL seq_count: got %0d want 3", fetch_count); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick(); tick();
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_pre_addr: got %h want 8", imem_addr); end
    pc_write = 1'b0;
    jump = 1'b1; jump_target = 32'h300;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b0 || instruction !== 32'h4 || pc_plus4 !== 32'h8 || fetch_count !== 32'd2 || imem_addr !== 32'h8)
        begin errors++; $display("FAIL stall_%0d: req %0b instr %h pc4 %h count %0d addr %h want 0 4 8 2 8", i, imem_req, instruction, pc_plus4, fetch_count, imem_addr); end
    end
    pc_write = 1'b1; jump = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || fetch_count !== 32'd2) begin errors++; $display("FAIL stall_resume: req %0b addr %h count %0d want 1 8 2", imem_req, imem_addr, fetch_count); end
    tick();
    checks++; if (instruction !== 32'h8 || fetch_count !== 32'd3 || imem_addr !== 32'hC) begin errors++; $display("FAIL stall_deliver: instr %h count %0d addr %h want 8 3 c", instruction, fetch_count, imem_addr); end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    checks++; if (imem_addr !== 32'h10 || fetch_count !== 32'd4) begin errors++; $display("FAIL redir_pre: addr %h count %0d want 10 4", imem_addr, fetch_count); end
    jump = 1'b1; jump_target = 32'h100;
    branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    jump = 1'b0; branch_taken = 1'b0;
    checks++; if (if_valid !== 1'b0 || instruction !== NOP || fetch_count !== 32'd4) begin errors++; $display("FAIL redir_bubble: valid %0b instr %h count %0d want 0 %h 4", if_valid, instruction, fetch_count, NOP); end
    checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL redir_addr: addr %h req %0b want 100 1", imem_addr, imem_req); end
    tick();
    checks++; if (instruction !== 32'h100 || if_valid !== 1'b1 || fetch_count !== 32'd5 || pc_plus4 !== 32'h104) begin errors++; $display("FAIL redir_deliver: instr %h valid %0b count %0d pc4 %h want 100 1 5 104", instruction, if_valid, fetch_count, pc_plus4); end
    branch_taken = 1'b1; branch_target = 32'h203;
    tick();
    branch_taken = 1'b0;
    checks++; if (imem_addr !== 32'h200 || if_valid !== 1'b0) begin errors++; $display("FAIL branch_align: addr %h valid %0b want 200 0", imem_addr, if_valid); end
    tick();
    checks++; if (instruction !== 32'h200 || fetch_count !== 32'd6) begin errors++; $display("FAIL branch_deliver: instr %h count %0d want 200 6", instruction, fetch_count); end
  endtask

  task automatic test_idle_redirect();
    rst = 1'b0;
    tick();
    jump = 1'b1; jump_target = 32'h40;
    @(negedge clk);
    rst = 1'b1;
    tick();
    jump = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL idle_redirect: req %0b addr %h want 1 40", imem_req, imem_addr); end
  endtask

  task automatic test_not_ready();
    do_reset();
    tick(); tick();
    checks++; if (fetch_count !== 32'd1 || imem_addr !== 32'h4) begin errors++; $display("FAIL nr_pre: count %0d addr %h want 1 4", fetch_count, imem_addr); end
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (if_valid !== 1'b0 || instruction !== NOP || imem_addr !== 32'h4 || fetch_count !== 32'd1 || imem_req !== 1'b1)
        begin errors++; $display("FAIL nr_bubble_%0d: valid %0b instr %h addr %h count %0d req %0b want 0 %h 4 1 1", i, if_valid, instruction, imem_addr, fetch_count, imem_req, NOP); end
    end
    imem_ready = 1'b1;
    tick();
    checks++; if (instruction !== 32'h4 || if_valid !== 1'b1 || fetch_count !== 32'd2 || imem_addr !== 32'h8) begin errors++; $display("FAIL nr_deliver: instr %h valid %0b count %0d addr %h want 4 1 2 8", instruction, if_valid, fetch_count, imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: req %0b addr %h want 1 fffffffc", w_req, w_addr); end
    tick();
    checks++; if (w_instr !== 32'hFFFF_FFFC || w_pc4 !== 32'h0 || w_addr !== 32'h0 || w_count !== 32'd1) begin errors++; $display("FAIL wrap_deliver: instr %h pc4 %h addr %h count %0d want fffffffc 0 0 1", w_instr, w_pc4, w_addr, w_count); end
    tick();
    checks++; if (w_instr !== 32'h0 || w_pc4 !== 32'h4 || w_valid !== 1'b1) begin errors++; $display("FAIL wrap_next: instr %h pc4 %h valid %0b want 0 4 1", w_instr, w_pc4, w_valid); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    tick(); tick(); tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instruction !== NOP || if_valid !== 1'b0 || fetch_count !== 32'd0 || pc_plus4 !== 32'd0 || imem_addr !== 32'd0)
      begin errors++; $display("FAIL async_reset: req %0b instr %h valid %0b count %0d pc4 %h addr %h", imem_req, instruction, if_valid, fetch_count, pc_plus4, imem_addr); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL restart_idle: req %0b want 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL restart_fetch: req %0b addr %h want 1 0", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_idle_redirect();
    test_not_ready();
    test_wrap();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
